// File: rtl/q_meter_pkg.sv
// Shared types and sizing helpers for the q_meter measurement front-end.
package q_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_PUBLISH = 2'd3
  } q_meter_state_t;

  // Holds the sum of 2^log2_avg unsigned bus_w-bit samples without overflow.
  function automatic int acc_width(input int bus_w, input int log2_avg);
    return bus_w + log2_avg;
  endfunction

endpackage

// File: rtl/q_meter_if.sv
// Sample/control bundle between the ADC/controller side (master) and q_meter (slave).
interface q_meter_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 enable;
  logic                 sample_valid;
  logic [BUS_WIDTH-1:0] sample;
  logic [BUS_WIDTH-1:0] i_ref;
  logic [BUS_WIDTH-1:0] q_measured;
  logic                 ready;
  logic                 busy;

  modport master (
    output enable, sample_valid, sample, i_ref,
    input  q_measured, ready, busy
  );

  modport slave (
    input  enable, sample_valid, sample, i_ref,
    output q_measured, ready, busy
  );
endinterface

// File: rtl/q_meter_accum.sv
// Sample accumulator: sums 2^LOG2_AVG samples, flags the final one, forms the averaged result.
// Latency: done/result are combinational on the accepting cycle; state updates next edge.
// Backpressure: none, every add is taken. Q_METER_ROUND_EN selects round-half-up over truncation.
module q_meter_accum
  import q_meter_pkg::*;
#(
  parameter int BUS_WIDTH = 10,
  parameter int LOG2_AVG  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 add,
  input  logic [BUS_WIDTH-1:0] sample,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] result
);
  localparam int ACC_W = acc_width(BUS_WIDTH, LOG2_AVG);
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

`ifdef Q_METER_ROUND_EN
  localparam int HALF_SH = (LOG2_AVG > 0) ? LOG2_AVG - 1 : 0;
  localparam logic [ACC_W-1:0] HALF = (LOG2_AVG > 0) ? (ACC_W'(1) << HALF_SH) : '0;
`else
  localparam logic [ACC_W-1:0] HALF = '0;
`endif

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] rnd;

  // Result is formed from the sum including the sample being accepted, so
  // the publish register can load on that same edge.
  assign sum    = acc + ACC_W'(sample);
  assign rnd    = sum + HALF;
  assign result = BUS_WIDTH'(rnd >> LOG2_AVG);
  assign done   = add && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= sum;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/q_meter.sv
// Settle-then-average Q measurement; one ready pulse per measurement at the current i_ref.
// Latency: SETTLE_CYCLES + 2^LOG2_AVG + 1 cycles from enable rise with continuous valid samples.
// Backpressure: none; samples outside ACCUM are dropped. Q_METER_ROUND_EN enables rounding.
module q_meter
  import q_meter_pkg::*;
#(
  parameter int BUS_WIDTH     = 10,
  parameter int SETTLE_CYCLES = 64,
  parameter int LOG2_AVG      = 3
) (
  input logic      clk,
  input logic      rst,
  q_meter_if.slave bus
);
  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_SETTLE  = ST_SETTLE;
  localparam logic [1:0] S_ACCUM   = ST_ACCUM;
  localparam logic [1:0] S_PUBLISH = ST_PUBLISH;
  // With no settle time every restart lands straight in ACCUM.
  localparam logic [1:0] S_RESUME  = (SETTLE_CYCLES == 0) ? S_ACCUM : S_SETTLE;

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

  logic [1:0]           state;
  logic [SC_W-1:0]      settle_cnt;
  logic [BUS_WIDTH-1:0] i_ref_q;
  logic [BUS_WIDTH-1:0] q_meas_r;
  logic                 ready_r;
  logic                 ref_chg;
  logic                 acc_add;
  logic                 acc_clear;
  logic                 acc_done;
  logic [BUS_WIDTH-1:0] acc_result;

  assign ref_chg   = ((state == S_SETTLE) || (state == S_ACCUM)) && (bus.i_ref != i_ref_q);
  assign acc_add   = (state == S_ACCUM) && bus.sample_valid && bus.enable && !ref_chg;
  assign acc_clear = (state != S_ACCUM) || ref_chg;

  q_meter_accum #(
    .BUS_WIDTH (BUS_WIDTH),
    .LOG2_AVG  (LOG2_AVG)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .add    (acc_add),
    .sample (bus.sample),
    .done   (acc_done),
    .result (acc_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      i_ref_q    <= '0;
      q_meas_r   <= '0;
      ready_r    <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      if ((state == S_IDLE) || ref_chg) begin
        i_ref_q <= bus.i_ref;
      end
      // Priority: enable low, then i_ref change, then final-sample completion.
      if (!bus.enable) begin
        state      <= S_IDLE;
        settle_cnt <= '0;
      end else if (ref_chg) begin
        state      <= S_RESUME;
        settle_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state      <= S_RESUME;
            settle_cnt <= '0;
          end
          S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state <= S_ACCUM;
            end else begin
              settle_cnt <= settle_cnt + SC_W'(1);
            end
          end
          S_ACCUM: begin
            if (acc_done) begin
              state    <= S_PUBLISH;
              ready_r  <= 1'b1;
              q_meas_r <= acc_result;
            end
          end
          default: begin
            state      <= S_RESUME;
            settle_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.q_measured = q_meas_r;
  assign bus.ready      = ready_r;
  assign bus.busy       = (state == S_SETTLE) || (state == S_ACCUM);

endmodule

// File: doc/q_meter.md
# q_meter

Measurement front-end that produces the averaged quality-factor reading `q_measured` and its one-cycle `ready` strobe for the bisection current-reference controller directly downstream. After every change of `i_ref`, it waits a programmable settling time. It then averages 2^LOG2_AVG valid ADC samples and publishes the result. It re-arms automatically, so each bisection step gets exactly one fresh measurement taken at the current `i_ref`.

## Interface
- `BUS_WIDTH`, 10: width of `sample`, `i_ref`, `q_measured`.
- `SETTLE_CYCLES`, 64: clock cycles waited after enable rise, `i_ref` change or publish before samples are accepted; 0 is legal.
- `LOG2_AVG`, 3: log2 of samples averaged per measurement; range 0..8.
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `enable` in 1: measurement enable; low forces IDLE.
- `sample_valid` in 1: qualifies `sample` for one cycle.
- `sample` in BUS_WIDTH: unsigned ADC Q sample.
- `i_ref` in BUS_WIDTH: current reference from the controller; any change restarts the measurement.
- `q_measured` out BUS_WIDTH: averaged result; registered and held between publishes.
- `ready` out 1: one-cycle pulse; `q_measured` is new in the same cycle.
- `busy` out 1: high in SETTLE and ACCUM.

## Operation
- States: IDLE, SETTLE, ACCUM, PUBLISH.
- IDLE:
  - Holds while `enable`=0.
  - Clears the settle counter, accumulator and sample counter.
  - Captures `i_ref` into `i_ref_q` every cycle.
  - Goes to SETTLE when `enable`=1.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then enters ACCUM.
  - With SETTLE_CYCLES=0, goes directly IDLE→ACCUM and PUBLISH→ACCUM.
  - Ignores `sample_valid`.
- ACCUM:
  - On each `sample_valid`, adds `sample` to the accumulator (ACC_W = BUS_WIDTH+LOG2_AVG bits, unsigned) and increments the sample counter.
  - When the 2^LOG2_AVG-th sample is accepted, enters PUBLISH.
- PUBLISH (one cycle):
  - `q_measured` <= accumulator >> LOG2_AVG.
  - `ready`=1.
  - Clears the accumulator and sample counter.
  - Goes to SETTLE.
- `i_ref` != `i_ref_q` in SETTLE or ACCUM:
  - Discards the partial accumulation.
  - Reloads the settle counter.
  - Updates `i_ref_q`.
  - Re-enters SETTLE.
- `enable` falling in any state:
  - Goes to IDLE next cycle; no `ready`.
  - `q_measured` holds its last value.
- Priority on the same edge: `rst` > `enable`=0 > `i_ref` change > final-sample completion.
  - If the final sample and an `i_ref` change coincide, the measurement restarts with no publish.

## Timing
- Reset values:
  - `q_measured`=0, `ready`=0, `busy`=0.
  - State IDLE; all counters and the accumulator 0.
- `ready`:
  - Registered; high exactly one cycle.
  - Asserted the cycle after the edge that accepted the final sample.
  - Never asserted back-to-back.
- `q_measured` changes only in the `ready` cycle and is stable in and after it.
- Minimum spacing between `ready` pulses: SETTLE_CYCLES + 2^LOG2_AVG + 1 cycles.
- Latency from enable rise (constant `i_ref`, `sample_valid`=1 continuously) to `ready`: SETTLE_CYCLES + 2^LOG2_AVG + 1 cycles.
- Asynchronous `rst` mid-measurement returns to reset values immediately; no `ready` is emitted.

## Configuration
- `Q_METER_ROUND_EN` defined:
  - Result = (accumulator + 2^(LOG2_AVG-1)) >> LOG2_AVG, round-half-up.
  - No rounding term when LOG2_AVG=0.
  - Overflow is impossible, so no saturation.
- `Q_METER_ROUND_EN` undefined: truncating shift.

## Structure
- Package `q_meter_pkg`:
  - State enum typedef `q_meter_state_t`.
  - Function `acc_width(bus_w, log2_avg)`.
- Sub-module `q_meter_accum`:
  - Accumulator, sample counter, `done` flag, `clear` input.
  - Computes the rounded/truncated result.
- Top `q_meter` holds the FSM, settle counter, `i_ref_q` compare and output registers.

## Test plan
All scenarios use BUS_WIDTH=10, SETTLE_CYCLES=4, LOG2_AVG=2.
- Reset: `rst`=1 with arbitrary inputs -> `q_measured`=0, `ready`=0, `busy`=0.
- Basic measurement: `enable`=1, constant `i_ref`, samples 100, 101, 102, 103 after settle.
  - Truncating: `q_measured`=101 with a single-cycle `ready` at cycle 4+4+1.
  - With `Q_METER_ROUND_EN`: `q_measured`=102.
- Settle masking: `sample`=1023 valid during the 4 settle cycles, then 4×200 -> `q_measured`=200.
- `i_ref` change after 2 accepted samples -> no `ready`, SETTLE restarts, then 4×50 -> `q_measured`=50.
- Full scale: 4×1023 -> `q_measured`=1023 in both configurations.
- Enable drop and mid-measurement reset:
  - `enable`=0 in ACCUM -> IDLE, no `ready`, previous `q_measured` held.
  - `rst` pulse in ACCUM -> all outputs 0.
